// File: rtl/me_buf_pkg.sv
// Shared constants and types for the motion-estimation reference buffer path.
// WORD_W      : width of one upstream word (8 luma pixels, pixel 0 in [7:0])
// ROW_WORDS   : words per picture row
// FRAME_ROWS  : rows per frame
// DEF_*       : default feeder geometry
// ref_word_t  : FIFO payload, one data word plus its start-of-frame flag
package me_buf_pkg;

  localparam int unsigned WORD_W          = 64;
  localparam int unsigned ROW_WORDS       = 480;
  localparam int unsigned FRAME_ROWS      = 2160;
  localparam int unsigned DEF_FRAME_WORDS = ROW_WORDS * FRAME_ROWS;
  localparam int unsigned DEF_FIFO_DEPTH  = 32;
  localparam int unsigned IDX_W           = 20;

  typedef struct packed {
    logic              sof;
    logic [WORD_W-1:0] data;
  } ref_word_t;

  localparam int unsigned REF_WORD_W = $bits(ref_word_t);

  // Advance a frame word index, wrapping after the last word of the frame.
  function automatic logic [IDX_W-1:0] idx_advance(input logic [IDX_W-1:0] idx,
                                                   input logic [IDX_W-1:0] last);
    return (idx == last) ? '0 : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/ref_word_fifo.sv
// Synchronous first-word-fall-through FIFO.
// clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
// wr_en      : write request, ignored while full
// wr_data    : word to store
// rd_en      : pop request, ignored while empty
// rd_data    : current head word, zero while empty
// not_empty  : head word is valid
// not_full   : registered space-available flag, low during reset
module ref_word_fifo #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             not_empty,
  output logic             not_full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             do_wr;
  logic             do_rd;

  // Pointer increment modulo DEPTH (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_wr     = wr_en & not_full;
  assign do_rd     = rd_en & not_empty;
  assign not_empty = (count != '0);
  assign rd_data   = not_empty ? mem[rd_ptr] : '0;

  // Occupancy after this edge; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_nxt = count;
    if (do_wr && !do_rd) begin
      count_nxt = count + CNT_W'(1);
    end else if (!do_wr && do_rd) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // Pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      not_full <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
      count    <= count_nxt;
      not_full <= (count_nxt < CNT_W'(DEPTH));
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ref_frame_feeder.sv
// Feeds reference-frame words from an upstream source into the previous-frame
// buffer, tracking the word position inside each frame.
// clk, rst     : clock, asynchronous active-high reset
// up_data      : upstream word, 8 luma pixels of one row
// up_valid     : up_data/up_sof valid
// up_sof       : first word of a frame
// up_ready     : a word is accepted this cycle when up_valid is also high
// in_en        : buffer consumes data_in at this edge
// data_in      : head word presented to the buffer, zero when empty
// data_vld     : data_in holds a real word
// frame_start  : pulse, an SOF word was consumed
// frame_done   : pulse, the last word of a frame was consumed
// underflow    : sticky, in_en seen while empty
// sof_err      : sticky, SOF and word index disagreed
module ref_frame_feeder
  import me_buf_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] up_data,
  input  logic              up_valid,
  input  logic              up_sof,
  output logic              up_ready,
  input  logic              in_en,
  output logic [WORD_W-1:0] data_in,
  output logic              data_vld,
  output logic              frame_start,
  output logic              frame_done,
  output logic              underflow,
  output logic              sof_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

  ref_word_t        wr_word;
  ref_word_t        rd_word;
  logic             push;
  logic             pop;
  logic             sof_seen;
  logic             frame_started;
  logic [IDX_W-1:0] word_idx;
  logic [IDX_W-1:0] eff_idx;

  // Until the first SOF after reset, non-SOF words are accepted and dropped
  // at the input so the buffer never sees a partial frame.
  assign push    = up_valid & up_ready & (sof_seen | up_sof);
  assign wr_word = '{sof: up_sof, data: up_data};
  assign pop     = in_en & data_vld;
  assign data_in = rd_word.data;

  // An SOF word is by definition index 0; this resyncs the index on a stray SOF.
  assign eff_idx = rd_word.sof ? '0 : word_idx;

  ref_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REF_WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (push),
    .wr_data   (wr_word),
    .rd_en     (in_en),
    .rd_data   (rd_word),
    .not_empty (data_vld),
    .not_full  (up_ready)
  );

  // Frame position tracking, event pulses and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sof_seen      <= 1'b0;
      frame_started <= 1'b0;
      word_idx      <= '0;
      frame_start   <= 1'b0;
      frame_done    <= 1'b0;
      underflow     <= 1'b0;
      sof_err       <= 1'b0;
    end else begin
      if (push && up_sof) sof_seen <= 1'b1;
      if (in_en && !data_vld) underflow <= 1'b1;
      frame_start <= pop & rd_word.sof;
      frame_done  <= pop & (eff_idx == LAST_IDX);
      if (pop) begin
        word_idx <= idx_advance(eff_idx, LAST_IDX);
        if (rd_word.sof) frame_started <= 1'b1;
        if (frame_started &&
            ((rd_word.sof && word_idx != '0) || (!rd_word.sof && word_idx == '0))) begin
          sof_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ref_frame_feeder.sv
module tb_ref_frame_feeder;

  localparam int FW    = 16;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] up_data = '0;
  logic        up_valid = 1'b0;
  logic        up_sof = 1'b0;
  logic        up_ready;
  logic        in_en = 1'b0;
  logic [63:0] data_in;
  logic        data_vld;
  logic        frame_start;
  logic        frame_done;
  logic        underflow;
  logic        sof_err;

  ref_frame_feeder #(
    .FIFO_DEPTH  (DEPTH),
    .FRAME_WORDS (FW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .up_data     (up_data),
    .up_valid    (up_valid),
    .up_sof      (up_sof),
    .up_ready    (up_ready),
    .in_en       (in_en),
    .data_in     (data_in),
    .data_vld    (data_vld),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .underflow   (underflow),
    .sof_err     (sof_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // ---------------- reference model (queue level) ----------------
  typedef struct packed {
    logic        sof;
    logic [63:0] data;
  } mw_t;

  mw_t mq[$];
  bit  m_ready, m_seen, m_started, m_fs, m_fd, m_uf, m_se;
  int  m_idx;

  task automatic model_reset();
    mq.delete();
    m_ready = 0; m_seen = 0; m_started = 0;
    m_fs = 0; m_fd = 0; m_uf = 0; m_se = 0;
    m_idx = 0;
  endtask

  task automatic model_edge(input logic v, input logic s, input logic [63:0] d, input logic en);
    bit  pop, push;
    mw_t w;
    int  eff;
    pop  = en && (mq.size() > 0);
    push = v && m_ready && (m_seen || s);
    if (en && mq.size() == 0) m_uf = 1;
    m_fs = 0;
    m_fd = 0;
    if (pop) begin
      w = mq.pop_front();
      if (w.sof) begin
        if (m_started && m_idx != 0) m_se = 1;
        eff = 0;
        m_started = 1;
        m_fs = 1;
      end else begin
        if (m_started && m_idx == 0) m_se = 1;
        eff = m_idx;
      end
      m_fd  = (eff == FW - 1);
      m_idx = (eff + 1) % FW;
    end
    if (push) begin
      mq.push_back('{sof: s, data: d});
      if (s) m_seen = 1;
    end
    m_ready = (mq.size() < DEPTH);
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [63:0] ed;
    logic        ev;
    ev = (mq.size() > 0);
    ed = ev ? mq[0].data : 64'd0;
    chk("model_data", data_in, ed);
    chk("model_flags",
        64'({up_ready, data_vld, frame_start, frame_done, underflow, sof_err}),
        64'({m_ready, ev, m_fs, m_fd, m_uf, m_se}));
  endtask

  task automatic step(input logic v, input logic s, input logic [63:0] d, input logic en);
    up_valid = v; up_sof = s; up_data = d; in_en = en;
    @(posedge clk);
    model_edge(v, s, d, en);
    #1;
    check_model();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 64'd0, 1'b0);
  endtask

  task automatic pop1();
    step(1'b0, 1'b0, 64'd0, 1'b1);
  endtask

  task automatic do_reset();
    up_valid = 0; up_sof = 0; up_data = '0; in_en = 0;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_flags", 64'({up_ready, data_vld, frame_start, frame_done, underflow, sof_err}), 64'd0);
    chk("rst_data", data_in, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", 64'({up_ready, data_vld, underflow, sof_err}), 64'd0);
    rst = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        v;
    logic        s;
    logic [63:0] d;
    logic        en;
    logic        e_vld;
    logic [63:0] e_data;
    logic        e_fs;
    logic        e_uf;
  } vec_t;

  vec_t tbl[8];

  logic        rv, rs, ren;
  logic [63:0] rd;
  int          tx;
  int          rate;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    // Stream 0x11..0x15 with in_en following one cycle behind the first push.
    tbl[0] = '{1'b0, 1'b0, 64'h00, 1'b0, 1'b0, 64'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 64'h11, 1'b0, 1'b1, 64'h11, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 64'h12, 1'b1, 1'b1, 64'h12, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 64'h13, 1'b1, 1'b1, 64'h13, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 64'h14, 1'b1, 1'b1, 64'h14, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 64'h15, 1'b1, 1'b1, 64'h15, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 64'h00, 1'b1, 1'b0, 64'h00, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 64'h00, 1'b0, 1'b0, 64'h00, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].en);
      chk($sformatf("tbl%0d_vld", i), 64'(data_vld), 64'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_data", i), data_in, tbl[i].e_data);
      chk($sformatf("tbl%0d_fs", i), 64'(frame_start), 64'(tbl[i].e_fs));
      chk($sformatf("tbl%0d_uf", i), 64'(underflow), 64'(tbl[i].e_uf));
    end

    // Fill to capacity, reject one, then drain.
    do_reset();
    idle();
    chk("ready_after_rst", 64'(up_ready), 64'd1);
    for (int i = 0; i < 32; i++) begin
      step(1'b1, (i == 0), 64'h100 + 64'(i), 1'b0);
      if (i == 30) chk("ready_at_31", 64'(up_ready), 64'd1);
    end
    chk("full_ready", 64'(up_ready), 64'd0);
    step(1'b1, 1'b0, 64'h1FF, 1'b0);
    chk("full_hold", 64'(up_ready), 64'd0);
    pop1();
    chk("ready_back", 64'(up_ready), 64'd1);
    chk("head_after_pop", data_in, 64'h101);
    for (int i = 1; i < 31; i++) pop1();
    chk("last_head", data_in, 64'h11F);
    pop1();
    chk("drained", 64'(data_vld), 64'd0);

    // Full frame with an underflow mid-frame, then a missing SOF.
    do_reset();
    idle();
    step(1'b1, 1'b1, 64'h200, 1'b0);
    step(1'b1, 1'b0, 64'h201, 1'b0);
    step(1'b1, 1'b0, 64'h202, 1'b0);
    pop1();
    chk("f_start", 64'(frame_start), 64'd1);
    pop1();
    pop1();
    pop1();
    chk("uf_set", 64'(underflow), 64'd1);
    chk("uf_vld", 64'(data_vld), 64'd0);
    for (int i = 3; i < 16; i++) step(1'b1, 1'b0, 64'h200 + 64'(i), 1'b0);
    for (int i = 3; i < 15; i++) begin
      pop1();
      chk("fd_early", 64'(frame_done), 64'd0);
    end
    pop1();
    chk("fd_pulse", 64'(frame_done), 64'd1);
    chk("fd_no_err", 64'(sof_err), 64'd0);
    step(1'b1, 1'b0, 64'h210, 1'b0);
    chk("fd_clear", 64'(frame_done), 64'd0);
    pop1();
    chk("sof_err_set", 64'(sof_err), 64'd1);
    chk("uf_sticky", 64'(underflow), 64'd1);
    repeat (3) idle();
    chk("sof_err_sticky", 64'(sof_err), 64'd1);

    // Words before the first SOF are dropped.
    do_reset();
    idle();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 64'h300 + 64'(i), 1'b0);
      chk("drop_vld", 64'(data_vld), 64'd0);
    end
    step(1'b1, 1'b1, 64'h3AA, 1'b0);
    chk("first_head", data_in, 64'h3AA);
    step(1'b1, 1'b0, 64'h3BB, 1'b1);
    chk("drop_fs", 64'(frame_start), 64'd1);
    chk("drop_next", data_in, 64'h3BB);
    pop1();
    chk("drop_no_err", 64'(sof_err), 64'd0);

    // Reset with words queued, then restart only at a new SOF.
    do_reset();
    idle();
    for (int i = 0; i < 10; i++) step(1'b1, (i == 0), 64'h400 + 64'(i), 1'b0);
    chk("queued_vld", 64'(data_vld), 64'd1);
    do_reset();
    idle();
    chk("rel_ready", 64'(up_ready), 64'd1);
    chk("rel_vld", 64'(data_vld), 64'd0);
    step(1'b1, 1'b0, 64'h500, 1'b0);
    chk("rel_drop", 64'(data_vld), 64'd0);

    // Randomized traffic against the model, with varying consumer rate.
    do_reset();
    tx = 0;
    rate = 6;
    for (int c = 0; c < 4000; c++) begin
      if (c % 400 == 0) rate = $urandom_range(1, 10);
      if ($urandom_range(0, 699) == 0) begin
        do_reset();
        tx = 0;
      end
      rv  = ($urandom_range(0, 9) < 7);
      ren = ($urandom_range(0, 9) < rate);
      rs  = ((tx % FW) == 0);
      if ($urandom_range(0, 59) == 0) rs = ~rs;
      rd  = {$urandom, $urandom};
      if (rv && m_ready && (m_seen || rs)) tx++;
      step(rv, rs, rd, ren);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
